// File: rtl/uart_pkg.sv
// Shared definitions for the debugger UART receive path: state encoding and
// default frame geometry.
package uart_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 434;  // 50 MHz / 115200 baud
  localparam int DEFAULT_DATA_BITS   = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    RECV_BIT   = 3'd2,
    STOP_BIT   = 3'd3,
    LOAD       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_e;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer for the UART receiver: pulses tick at the end of a full or
// half bit period; restarted by the receiver on every state change.
module rx_bit_timer
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic clk,
  input  logic n_Rst,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] FULL_LIMIT = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LIMIT = CW'(CLK_PER_BIT / 2 - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] limit;

  assign limit = half ? HALF_LIMIT : FULL_LIMIT;
  assign tick  = (count == limit);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rcu.sv
// UART receive control unit: synchronises serial_in, frames 8N1 data LSB-first
// and hands bytes to the debugger through a ready/read handshake.
module uart_rcu
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int DATA_BITS   = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_Rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 rx_state
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_e state, state_next;

  logic sync_1, rx_s, rx_d;
  logic start_edge;
  logic tick;
  logic shift_en, load_en, fe_set;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  // Synchroniser flops reset to 1 so an idle line never looks like a start edge.
  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
      rx_d   <= 1'b1;
    end else begin
      sync_1 <= serial_in;
      rx_s   <= sync_1;
      rx_d   <= rx_s;
    end
  end

  assign start_edge = rx_d & ~rx_s;

  rx_bit_timer #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_timer (
    .clk   (clk),
    .n_Rst (n_Rst),
    .clear (state_next != state),
    .half  (state == START_BIT),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    load_en    = 1'b0;
    fe_set     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_edge) state_next = START_BIT;
      end
      START_BIT: begin
        if (tick) state_next = rx_s ? IDLE : RECV_BIT;
      end
      RECV_BIT: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_next = STOP_BIT;
        end
      end
      STOP_BIT: begin
        if (tick) begin
          if (rx_s) begin
            state_next = LOAD;
          end else begin
            fe_set     = 1'b1;
            state_next = BREAK_WAIT;
          end
        end
      end
      LOAD: begin
        load_en    = 1'b1;
        state_next = IDLE;
      end
      BREAK_WAIT: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Data arrives LSB-first, so shifting right leaves bit 0 at the bottom.
  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      if (state != RECV_BIT) bit_cnt <= '0;
      else if (shift_en)     bit_cnt <= bit_cnt + BW'(1);
    end
  end

  // A load and a debugger read in the same cycle: the new byte stays ready.
  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else if (load_en) begin
      rx_data       <= shift_reg;
      data_ready    <= 1'b1;
      framing_error <= 1'b0;
      if (data_ready && !data_read) overrun_error <= 1'b1;
      else if (data_read)           overrun_error <= 1'b0;
    end else begin
      if (fe_set) framing_error <= 1'b1;
      if (data_read && data_ready) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
    end
  end

  assign rx_state = (state != IDLE);

endmodule

// File: doc/uart_rcu.md
Name: uart_rcu

Overview:
UART receiver for the debugger serial link; it is the receive counterpart of the transmitter control unit.
- Synchronises the asynchronous serial_in line and detects the start bit.
- Samples 8 data bits LSB-first at mid-bit, then checks the stop bit.
- Presents the received byte to the debugger through a ready/read handshake, with framing-error and overrun flags.
- Sits between the chip-level RX pad and the debugger command decoder.

Parameters:
CLK_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); must be an even number >= 8
DATA_BITS, 8, data bits per frame (no parity, 1 stop bit)

Ports:
clk  in  1  system clock
n_Rst  in  1  reset, asynchronous, active-low
serial_in  in  1  asynchronous RX line, idle high
data_read  in  1  debugger pops rx_data; 1-cycle pulse
rx_data  out  8  last correctly framed byte
data_ready  out  1  rx_data holds an unread byte
framing_error  out  1  last frame had a low stop bit; sticky
overrun_error  out  1  unread byte was overwritten; sticky
rx_state  out  1  0 = IDLE, 1 = BUSY (any state other than IDLE)

Behaviour:
Reset:
- Asynchronous, via n_Rst low. All outputs go to 0 and rx_data to 0x00.
- Synchroniser flops reset to 1 (line idle).
- FSM goes to IDLE; timer and bit counter are cleared.
- Reset mid-frame abandons the frame; no partial data is kept.

Synchroniser and edge detect:
- 2-flop synchroniser on serial_in gives rx_s; a further delay flop gives rx_d.
- Start edge = rx_d & ~rx_s.

Bit timer:
- Counts 0..limit, then wraps to 0.
- Asserts `tick` for one cycle at terminal count.
- Counter is cleared on every state entry.

FSM states and transitions:
- IDLE: start edge -> START_BIT.
- START_BIT: limit = CLK_PER_BIT/2 - 1. On tick, sample rx_s:
  - rx_s == 0 -> RECV_BIT, bit counter = 0.
  - rx_s == 1 -> IDLE (glitch rejected, no flags).
- RECV_BIT: limit = CLK_PER_BIT - 1. On tick, shift rx_s into the MSB of the shift register (right shift, so LSB arrives first) and increment the bit counter.
  - After DATA_BITS samples -> STOP_BIT.
- STOP_BIT: limit = CLK_PER_BIT - 1. On tick:
  - rx_s == 1 -> LOAD.
  - rx_s == 0 -> framing_error <= 1, go to BREAK_WAIT; the byte is discarded.
- BREAK_WAIT: waits for rx_s == 1 -> IDLE. This rides out a break condition without false start edges.
- LOAD: single cycle. rx_data <= shift register and data_ready <= 1, both visible the cycle after LOAD.
  - framing_error <= 0 on a good load.
  - If data_ready == 1 and data_read == 0 in this cycle: overrun_error <= 1 and rx_data is overwritten with the new byte.
  - Next state is IDLE. A start edge can be accepted in the first IDLE cycle, so back-to-back frames are received.

Handshake:
- data_read with data_ready == 1: data_ready <= 0 and overrun_error <= 0 next cycle.
- data_read with data_ready == 0: ignored.
- data_read in the LOAD cycle: the load wins. data_ready stays 1, no overrun, and overrun_error is cleared.

Latency: falling edge of serial_in to first start-bit sample = 2 (sync) + 1 (edge) + CLK_PER_BIT/2 cycles, ±1.

serial_in is not sampled outside START_BIT, RECV_BIT and STOP_BIT ticks, except for edge detect in IDLE and the line-high check in BREAK_WAIT.

Decomposition:
- Package uart_pkg:
  - rx state encoding IDLE, START_BIT, RECV_BIT, STOP_BIT, LOAD, BREAK_WAIT (3-bit).
  - DATA_BITS default.
  - Default CLK_PER_BIT.
- Sub-module rx_bit_timer:
  - Inputs: clk, n_Rst, clear, half (selects CLK_PER_BIT/2 - 1 limit).
  - Output: tick.
  - Counter width $clog2(CLK_PER_BIT).
- Synchroniser, FSM, shift register, bit counter and flags stay in uart_rcu.

Test Plan:
All scenarios use CLK_PER_BIT = 16.
1. Drive frame for 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> rx_data = 0xA5, data_ready = 1 about 152 cycles after the start edge; no error flags; data_read clears data_ready next cycle.
2. Low pulse of 4 cycles on idle line -> return to IDLE after the half-bit sample; data_ready = 0, no flags, rx_state back to 0.
3. Frame 0x3C with stop bit held low for 3 bit times -> framing_error = 1, data_ready = 0, rx_data unchanged; no reception until line returns high. A following good 0x11 frame gives rx_data = 0x11 and framing_error = 0.
4. Back-to-back frames 0x01 then 0xFE with no data_read -> rx_data = 0xFE, data_ready = 1, overrun_error = 1; data_read clears both.
5. data_read pulsed exactly in the LOAD cycle of the second of two frames -> data_ready = 1, overrun_error = 0, rx_data = second byte.
6. Assert n_Rst low mid-RECV_BIT (bit 4) -> all outputs 0 and rx_state = 0 immediately; a subsequent 0x5A frame is received correctly.
